// File: rtl/macro_readout.sv
// macro_readout: gathers BEATS input beats of LANE_NUM channels each into one
// CHANNEL_NUM-channel frame of 4-bit macro results and hands it on with a
// one-cycle data_out_valid pulse. Framing errors raise a sticky sync_err.
// Optional feature: define MACRO_READOUT_FRAME_CNT_EN to add a 16-bit
// frame_cnt output counting completed frames (wraps 65535 -> 0).
module macro_readout #(
  parameter int CHANNEL_NUM = 128,
  parameter int MACRO_NUM   = 4,
  parameter int LANE_NUM    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               macro_valid,
  input  logic                               macro_sof,
  input  logic [LANE_NUM*MACRO_NUM*4-1:0]    macro_data,
  output logic                               macro_ready,
  input  logic                               err_clr,
  output logic                               data_out_valid,
  output logic [CHANNEL_NUM*MACRO_NUM*4-1:0] data_out,
  output logic                               sync_err
`ifdef MACRO_READOUT_FRAME_CNT_EN
  ,
  output logic [15:0]                        frame_cnt
`endif
);

  localparam int BEATS  = CHANNEL_NUM / LANE_NUM;
  localparam int CW     = $clog2(BEATS);
  localparam int BEAT_W = LANE_NUM * MACRO_NUM * 4;
  // The last beat goes straight from macro_data into data_out, so the
  // collect buffer only needs room for the first BEATS-1 beats.
  localparam int BUF_W  = (BEATS - 1) * BEAT_W;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                                r_state;
  state_t                                w_state_next;
  logic [CW-1:0]                         r_beat_cnt;
  logic [CW-1:0]                         w_beat_cnt_next;
  logic [BUF_W-1:0]                      r_buf;
  logic [CHANNEL_NUM*MACRO_NUM*4-1:0]    r_data_out;
  logic                                  r_data_out_valid;
  logic                                  r_sync_err;
  logic                                  w_accept;
  logic                                  w_wr_en;
  logic [CW-1:0]                         w_wr_idx;
  logic                                  w_set_err;
  logic                                  w_frame_done;
  logic [CHANNEL_NUM*MACRO_NUM*4-1:0]    w_frame;

  // Ready is held low while in reset so nothing is handshaken during it.
  assign macro_ready    = (r_state != DONE) && !rst;
  assign w_accept       = macro_valid && macro_ready;
  assign w_frame        = {macro_data, r_buf};
  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign sync_err       = r_sync_err;

  // State and beat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  // Next-state, buffer write control, error and frame-complete decode.
  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_wr_en         = 1'b0;
    w_wr_idx        = r_beat_cnt;
    w_set_err       = 1'b0;
    w_frame_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (macro_sof) begin
            w_wr_en         = 1'b1;
            w_wr_idx        = '0;
            w_beat_cnt_next = CW'(1);
            w_state_next    = COLLECT;
          end else begin
            // Mid-frame beat with no frame open: drop it.
            w_set_err = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (w_accept) begin
          if (macro_sof) begin
            // Restart: the new beat 0 simply overwrites the partial frame.
            w_wr_en         = 1'b1;
            w_wr_idx        = '0;
            w_beat_cnt_next = CW'(1);
            w_set_err       = 1'b1;
          end else if (r_beat_cnt == LAST_BEAT) begin
            w_frame_done    = 1'b1;
            w_beat_cnt_next = '0;
            w_state_next    = DONE;
          end else begin
            w_wr_en         = 1'b1;
            w_beat_cnt_next = r_beat_cnt + CW'(1);
          end
        end
      end
      DONE: begin
        w_state_next    = IDLE;
        w_beat_cnt_next = '0;
      end
      default: begin
        w_state_next    = IDLE;
        w_beat_cnt_next = '0;
      end
    endcase
  end

  // Collect buffer: write the accepted beat into its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
    end else begin
      for (int b = 0; b < BEATS - 1; b++) begin
        if (w_wr_en && (w_wr_idx == CW'(b))) begin
          r_buf[b*BEAT_W +: BEAT_W] <= macro_data;
        end
      end
    end
  end

  // Frame output: update only when a full frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_data_out_valid <= w_frame_done;
      if (w_frame_done) begin
        r_data_out <= w_frame;
      end
    end
  end

  // Sticky framing error; a new error takes priority over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_err <= 1'b0;
    end else if (w_set_err) begin
      r_sync_err <= 1'b1;
    end else if (err_clr) begin
      r_sync_err <= 1'b0;
    end
  end

`ifdef MACRO_READOUT_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  assign frame_cnt = r_frame_cnt;

  // Completed-frame counter, advanced in the data_out_valid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (r_data_out_valid) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_macro_readout.sv
// Testbench for macro_readout (default build). Table-driven vectors, a few
// hand-written multi-cycle sequences and randomized traffic, all checked
// against a queue-based frame model.
module tb_macro_readout;
  localparam int CHANNEL_NUM = 128;
  localparam int MACRO_NUM   = 4;
  localparam int LANE_NUM    = 16;
  localparam int BEATS       = CHANNEL_NUM / LANE_NUM;
  localparam int LW          = LANE_NUM * MACRO_NUM * 4;
  localparam int FW          = CHANNEL_NUM * MACRO_NUM * 4;

  logic          clk;
  logic          rst;
  logic          macro_valid;
  logic          macro_sof;
  logic [LW-1:0] macro_data;
  logic          macro_ready;
  logic          err_clr;
  logic          data_out_valid;
  logic [FW-1:0] data_out;
  logic          sync_err;

  int n_checks = 0;
  int n_pass   = 0;

  macro_readout #(
    .CHANNEL_NUM(CHANNEL_NUM),
    .MACRO_NUM  (MACRO_NUM),
    .LANE_NUM   (LANE_NUM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .macro_valid   (macro_valid),
    .macro_sof     (macro_sof),
    .macro_data    (macro_data),
    .macro_ready   (macro_ready),
    .err_clr       (err_clr),
    .data_out_valid(data_out_valid),
    .data_out      (data_out),
    .sync_err      (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chkframe(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int bad;
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      bad = -1;
      for (int i = 0; i < FW / 4; i++)
        if (bad < 0 && act[i*4 +: 4] !== exp[i*4 +: 4]) bad = i;
      if (bad < 0) bad = 0;
      $display("FAIL %s: channel %0d macro %0d got %h want %h at %0t", name,
               bad / MACRO_NUM, bad % MACRO_NUM, act[bad*4 +: 4], exp[bad*4 +: 4], $time);
    end
  endtask

  // ---------------- data builders ----------------
  function automatic logic [LW-1:0] beat_fill(input logic [3:0] n);
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 4; i++) r[i*4 +: 4] = n;
    return r;
  endfunction

  function automatic logic [FW-1:0] frame_fill(input logic [3:0] n);
    logic [FW-1:0] r;
    for (int i = 0; i < FW / 4; i++) r[i*4 +: 4] = n;
    return r;
  endfunction

  // Channels 16k..16k+15 all carry nibble k.
  function automatic logic [FW-1:0] frame_ramp();
    logic [FW-1:0] r;
    for (int i = 0; i < FW / 4; i++) r[i*4 +: 4] = 4'((i / MACRO_NUM) / LANE_NUM);
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Open frame = beats gathered so far; an empty queue means no frame open.
  logic [LW-1:0] m_q[$];
  logic          m_done;
  logic          m_dv;
  logic          m_err;
  logic [FW-1:0] m_out;

  task automatic model_reset();
    m_q.delete();
    m_done = 1'b0;
    m_dv   = 1'b0;
    m_err  = 1'b0;
    m_out  = '0;
  endtask

  task automatic model_advance(input logic v, input logic s, input logic [LW-1:0] d, input logic c);
    logic acc, set_e, new_dv;
    acc    = v && !m_done;
    set_e  = 1'b0;
    new_dv = 1'b0;
    if (acc) begin
      if (s) begin
        if (m_q.size() != 0) set_e = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        set_e = 1'b1;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == BEATS) begin
          for (int b = 0; b < BEATS; b++) m_out[b*LW +: LW] = m_q[b];
          new_dv = 1'b1;
          m_q.delete();
        end
      end
    end
    m_done = new_dv;
    m_dv   = new_dv;
    if (set_e) m_err = 1'b1;
    else if (c) m_err = 1'b0;
  endtask

  task automatic check_outputs();
    chk1("macro_ready", macro_ready, !m_done);
    chk1("data_out_valid", data_out_valid, m_dv);
    chk1("sync_err", sync_err, m_err);
    chkframe("data_out", data_out, m_out);
  endtask

  // One cycle: check state left by the previous edge, then drive new inputs.
  task automatic step(input logic v, input logic s, input logic [LW-1:0] d, input logic c);
    @(negedge clk);
    check_outputs();
    macro_valid = v;
    macro_sof   = s;
    macro_data  = d;
    err_clr     = c;
    model_advance(v, s, d, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    macro_valid = 1'b0;
    macro_sof   = 1'b0;
    err_clr     = 1'b0;
    macro_data  = '0;
    #1;
    chk1("rst macro_ready", macro_ready, 1'b0);
    chk1("rst data_out_valid", data_out_valid, 1'b0);
    chk1("rst sync_err", sync_err, 1'b0);
    chkframe("rst data_out", data_out, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic       s;
    logic [3:0] nib;
    logic       c;
    logic       e_rdy;
    logic       e_dv;
    logic       e_err;
    logic       e_ramp;  // 1: data_out must be the ramp frame, 0: all zero
  } vec_t;

  function automatic vec_t mk(input logic v, input logic s, input logic [3:0] nib, input logic c,
                              input logic e_rdy, input logic e_dv, input logic e_err, input logic e_ramp);
    vec_t r;
    r.v = v; r.s = s; r.nib = nib; r.c = c;
    r.e_rdy = e_rdy; r.e_dv = e_dv; r.e_err = e_err; r.e_ramp = e_ramp;
    return r;
  endfunction

  vec_t tbl [14];

  initial begin
    int dv1, dv2, nrdy0;
    logic [LW-1:0] rd;
    logic rv, rs, rc;

    rst = 1'b1; macro_valid = 1'b0; macro_sof = 1'b0; err_clr = 1'b0; macro_data = '0;
    model_reset();

    // Expected values are those seen one edge after the row is applied.
    tbl[0] = mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 7; i++) tbl[i] = mk(1'b1, 1'b0, 4'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); // frame done
    tbl[8]  = mk(1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // ignored in DONE
    tbl[9]  = mk(1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); // no-sof in IDLE
    tbl[10] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // clear
    tbl[11] = mk(1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); // error beats clear
    tbl[12] = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); // sticky
    tbl[13] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // clear

    do_reset();
    for (int i = 0; i < 14; i++) begin
      macro_valid = tbl[i].v;
      macro_sof   = tbl[i].s;
      macro_data  = beat_fill(tbl[i].nib);
      err_clr     = tbl[i].c;
      @(negedge clk);
      chk1($sformatf("vec%0d macro_ready", i), macro_ready, tbl[i].e_rdy);
      chk1($sformatf("vec%0d data_out_valid", i), data_out_valid, tbl[i].e_dv);
      chk1($sformatf("vec%0d sync_err", i), sync_err, tbl[i].e_err);
      chkframe($sformatf("vec%0d data_out", i), data_out, tbl[i].e_ramp ? frame_ramp() : '0);
    end

    // Back-to-back frames with valid held high.
    do_reset();
    dv1 = -1; dv2 = -1; nrdy0 = 0;
    for (int t = 0; t < 20; t++) begin
      step(t <= 17, (t == 0 || t == 8 || t == 9), beat_fill(4'(t)), 1'b0);
      if (data_out_valid === 1'b1) begin
        if (dv1 < 0) dv1 = t;
        else if (dv2 < 0) dv2 = t;
      end
      if (macro_ready !== 1'b1) nrdy0++;
    end
    chk_int("first frame valid cycle", dv1, 8);
    chk_int("frame to frame gap", dv2 - dv1, 9);
    chk_int("ready low cycles", nrdy0, 2);

    // Frame A, aborted frame B, then restart with 0x5.
    do_reset();
    step(1'b1, 1'b1, beat_fill(4'hA), 1'b0);
    for (int k = 1; k < BEATS; k++) step(1'b1, 1'b0, beat_fill(4'hA), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, beat_fill(4'hF), 1'b0);
    step(1'b1, 1'b0, beat_fill(4'hF), 1'b0);
    step(1'b1, 1'b0, beat_fill(4'hF), 1'b0);
    step(1'b1, 1'b1, beat_fill(4'h5), 1'b0);
    step(1'b1, 1'b0, beat_fill(4'h5), 1'b0);
    step(1'b1, 1'b0, beat_fill(4'h5), 1'b0);
    step(1'b1, 1'b0, beat_fill(4'h5), 1'b0);
    chk1("restart sync_err", sync_err, 1'b1);
    chkframe("restart holds frame A", data_out, frame_fill(4'hA));
    for (int k = 4; k < BEATS; k++) step(1'b1, 1'b0, beat_fill(4'h5), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk1("restart frame valid", data_out_valid, 1'b1);
    chkframe("restart frame", data_out, frame_fill(4'h5));

    // Reset in the middle of a frame.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, (k == 0), beat_fill(4'(k)), 1'b0);
    do_reset();
    step(1'b1, 1'b0, beat_fill(4'd1), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < BEATS; k++) step(1'b1, (k == 0), beat_fill(4'(k)), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk1("post-reset frame valid", data_out_valid, 1'b1);
    chkframe("post-reset frame", data_out, frame_ramp());

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        rv = ($urandom_range(0, 9) < 8);
        if (m_q.size() == 0) rs = ($urandom_range(0, 9) < 9);
        else rs = ($urandom_range(0, 19) == 0);
        rc = ($urandom_range(0, 29) == 0);
        for (int w = 0; w < LW / 32; w++) rd[w*32 +: 32] = $urandom();
        step(rv, rs, rd, rc);
      end
    end
    step(1'b0, 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/macro_readout.md
MACRO_READOUT -- requirements
Module: macro_readout

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 128: output channels per frame.
REQ-002 SHALL have parameter MACRO_NUM, default 4: macros per channel.
REQ-003 SHALL have parameter LANE_NUM, default 16: channels per input beat; BEATS = CHANNEL_NUM/LANE_NUM; CHANNEL_NUM divisible by LANE_NUM; BEATS >= 2.
REQ-004 SHALL have clk  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have macro_valid  input  1: input beat present.
REQ-007 SHALL have macro_sof  input  1: current beat is beat 0 of a frame.
REQ-008 SHALL have macro_data  input  [LANE_NUM][MACRO_NUM] x 4: one beat of 4-bit macro results.
REQ-009 SHALL have macro_ready  output  1: beat accepted when macro_valid && macro_ready.
REQ-010 SHALL have err_clr  input  1: clears sync_err.
REQ-011 SHALL have data_out_valid  output  1: one-cycle frame-complete pulse, drives partial_sum data_in_valid.
REQ-012 SHALL have data_out  output  [CHANNEL_NUM][MACRO_NUM] x 4: assembled frame, drives partial_sum data_in.
REQ-013 SHALL have sync_err  output  1: sticky framing error flag.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, DONE with 3-bit-max beat counter beat_cnt (width clog2(BEATS)).
REQ-015 SHALL drive macro_ready = 1 in IDLE and COLLECT, 0 in DONE.
REQ-016 In IDLE, an accepted beat with macro_sof=1 SHALL be stored as beat 0, set beat_cnt=1, go to COLLECT.
REQ-017 In IDLE, an accepted beat with macro_sof=0 SHALL be dropped and set sync_err.
REQ-018 In COLLECT, an accepted beat with macro_sof=0 SHALL be stored to channels [beat_cnt*LANE_NUM +: LANE_NUM] of the collect buffer and increment beat_cnt.
REQ-019 In COLLECT, an accepted beat with macro_sof=1 SHALL discard the partial frame, be stored as beat 0, set beat_cnt=1, set sync_err.
REQ-020 On acceptance of beat BEATS-1 (macro_sof=0), the next cycle SHALL present the full frame (including that beat) on data_out, assert data_out_valid for exactly one cycle, and be in DONE.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE with beat_cnt=0; macro_valid during DONE is ignored.
REQ-022 data_out SHALL hold its value from one DONE until the next DONE; partial frames SHALL never alter data_out.
REQ-023 Cycles with macro_valid=0 in COLLECT SHALL hold state and counter (no timeout).
REQ-024 err_clr SHALL clear sync_err next cycle; a simultaneous new error SHALL win (sync_err stays 1).
REQ-025 Frame-to-frame throughput SHALL be BEATS+1 cycles minimum.

Reset
REQ-026 While rst=1: state IDLE, beat_cnt 0, collect buffer 0, data_out all 0, data_out_valid 0, sync_err 0, macro_ready 0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame immediately; first beat after release SHALL require macro_sof=1.

Configuration
REQ-028 Macro MACRO_READOUT_FRAME_CNT_EN defined: SHALL add output frame_cnt [15:0], reset 0, incremented in the cycle data_out_valid=1, wrapping 65535->0.
REQ-029 Macro MACRO_READOUT_FRAME_CNT_EN undefined: frame_cnt port and logic SHALL not exist; all other behaviour identical.

Verification
REQ-030 Defaults, 8 back-to-back beats, beat k all nibbles = k, sof on beat 0 -> data_out_valid one cycle after beat 7; channels 16k..16k+15 all nibbles = k; sync_err 0.
REQ-031 Two consecutive frames, macro_valid held 1 -> macro_ready 0 only in each DONE cycle; second data_out_valid 9 cycles after first.
REQ-032 Frame A complete, then 3 beats of frame B with nibbles 0xF, then sof restart with nibbles 0x5 x8 -> sync_err=1, data_out unchanged (frame A) until new frame complete, then all 0x5.
REQ-033 Beat with macro_sof=0 in IDLE -> dropped, sync_err=1; err_clr pulse -> sync_err=0 next cycle.
REQ-034 rst pulse after beat 4 -> all outputs 0; fresh 8-beat frame completes normally.
REQ-035 With MACRO_READOUT_FRAME_CNT_EN, 65537 frames -> frame_cnt = 1.
